btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Multi-channel push-button input conditioner that sits between the raw board buttons and the LED display logic. Each channel synchronizes its asynchronous button, debounces it with a cycle counter, and produces registered level, single-cycle press/release pulses, and optional auto-repeat pulses while held. Downstream logic consumes clean pulses and never needs its own edge detection.

## Interface
- N_BTN, 2: number of independent button channels (≥1)
- DEBOUNCE_CYC, 1_000_000: cycles the synchronized input must be stable before a transition is accepted (≥1)
- REPEAT_DLY, 50_000_000: cycles from o_press to the first o_repeat; 0 disables auto-repeat
- REPEAT_PER, 20_000_000: cycles between subsequent o_repeat pulses (≥1)

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, synchronous, active-high
- i_btn  input  N_BTN  raw asynchronous buttons, active-high
- o_level  output  N_BTN  debounced button level
- o_press  output  N_BTN  1-cycle pulse on accepted press
- o_release  output  N_BTN  1-cycle pulse on accepted release
- o_repeat  output  N_BTN  1-cycle auto-repeat pulse while held

## Operation
- Clock: i_clk. Reset: i_rst, synchronous, active-high.
- Per channel: 2-flop synchronizer -> btn_s; FSM with debounce counter db_cnt and hold counter hold_cnt.
- States: IDLE, DB_PRESS, HELD, DB_REL.
- IDLE: btn_s=1 -> DB_PRESS, db_cnt=0.
- DB_PRESS: btn_s=0 -> IDLE (glitch rejected, no output). btn_s=1 and db_cnt==DEBOUNCE_CYC-1 -> HELD, o_press=1, o_level=1, hold_cnt=0, phase=first. Else db_cnt++.
- HELD: btn_s=0 -> DB_REL, db_cnt=0, hold_cnt frozen. Else if REPEAT_DLY≠0: hold_cnt==limit-1 (limit=REPEAT_DLY in first phase, REPEAT_PER afterwards) -> o_repeat=1, hold_cnt=0, phase=periodic; else hold_cnt++.
- DB_REL: btn_s=1 -> HELD (bounce rejected, no release; hold_cnt resumes from frozen value). btn_s=0 and db_cnt==DEBOUNCE_CYC-1 -> IDLE, o_release=1, o_level=0. Else db_cnt++.
- Counter width: $clog2(max(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER)+1); no wrap possible.
- Channels fully independent; simultaneous events on different channels produce simultaneous pulses.
- Button held through reset deassertion is treated as a new press (debounced, then o_press).

## Timing
- Reset: sync flops, state=IDLE, counters, phase, and all outputs = 0 on the cycle after i_rst sampled high. Reset mid-debounce aborts with no pulse.
- All outputs are registered; pulses are exactly 1 cycle.
- Raw rising edge sampled at edge E -> o_press high in the cycle after edge E+DEBOUNCE_CYC+2; o_level rises in the same cycle.
- Release latency: identical, with o_release and o_level falling.
- Synchronized high of ≤DEBOUNCE_CYC cycles -> no o_press; ≥DEBOUNCE_CYC+1 -> exactly one.
- First o_repeat REPEAT_DLY cycles after o_press, then every REPEAT_PER cycles, plus any cycles spent in rejected DB_REL bounces.
- o_press, o_repeat, and o_release are mutually exclusive per channel per cycle.

## Structure
- btn_pkg: btn_state_e enum (IDLE, DB_PRESS, HELD, DB_REL) and counter-width function.
- Sub-module btn_channel: one synchronizer + FSM + counters. btn_conditioner instantiates N_BTN copies in a generate loop.

## Test plan
Params: N_BTN=2, DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3.
- Reset with i_btn=2'b11 -> all outputs 0; after release, o_press on both channels 7 cycles after the first sampling edge.
- btn0 high 4 cycles -> no pulses. btn0 high 5 cycles -> one o_press; o_release once btn0 is low for 5 cycles.
- btn0 held 40 cycles -> o_press at t, o_repeat at t+10, t+13, t+16, …; no o_repeat after o_release.
- While held, btn0 drops for 3 cycles then returns -> no o_release, o_level stays 1, next o_repeat delayed by those 3 cycles.
- btn0 and btn1 pressed on the same edge -> o_press=2'b11 in the same cycle; btn1 then released -> btn0 repeats unaffected.
- i_rst asserted mid-DB_PRESS and mid-HELD -> no pulse, o_level=0 next cycle, FSM restarts from IDLE.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   btn_state_e : per-channel debounce/hold FSM state
//   cnt_width   : bit width that holds the largest of the three cycle counts
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } btn_state_e;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return unsigned'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, hold/repeat
// counter and registered outputs.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_btn        : raw asynchronous button (active-high)
//   o_level      : debounced level
//   o_press      : 1-cycle pulse on accepted press
//   o_release    : 1-cycle pulse on accepted release
//   o_repeat     : 1-cycle auto-repeat pulse while held
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DLY   = 50_000_000,
  parameter int unsigned REPEAT_PER   = 20_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);

  logic [1:0]    sync_q;
  logic          btn_s;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          phase_q, phase_d;   // 0: waiting for first repeat, 1: periodic
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  logic          db_last;
  logic [CW-1:0] hold_last;
  logic          hold_hit;

  assign btn_s     = sync_q[1];
  assign db_last   = (db_cnt_q == CW'(DEBOUNCE_CYC - 1));
  assign hold_last = phase_q ? CW'(REPEAT_PER - 1) : CW'(REPEAT_DLY - 1);
  assign hold_hit  = (REPEAT_DLY != 0) && (hold_cnt_q == hold_last);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      phase_q    <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_btn};
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      phase_q    <= phase_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    phase_d    = phase_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (db_last) begin
          state_d    = HELD;
          hold_cnt_d = '0;
          phase_d    = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      HELD, DB_REL: begin
        if (state_q == HELD && !btn_s) begin
          state_d  = DB_REL;
          db_cnt_d = '0;
        end else if (state_q == DB_REL && !btn_s) begin
          if (db_last) state_d = IDLE;
          else         db_cnt_d = db_cnt_q + CW'(1);
        end else begin
          // The edge that returns from a rejected bounce also advances the
          // hold counter, so repeats slip by exactly the cycles spent in DB_REL.
          state_d = HELD;
          if (REPEAT_DLY != 0) begin
            if (hold_hit) begin
              hold_cnt_d = '0;
              phase_d    = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic (registered in the state register process)
  always_comb begin
    press_d   = (state_q == DB_PRESS) && btn_s && db_last;
    release_d = (state_q == DB_REL) && !btn_s && db_last;
    repeat_d  = ((state_q == HELD) || (state_q == DB_REL)) && btn_s && hold_hit;
    level_d   = level_q;
    if (press_d)   level_d = 1'b1;
    if (release_d) level_d = 1'b0;
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: N_BTN independent btn_channel
// instances, each producing a debounced level and press/release/repeat pulses.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_btn        : raw asynchronous buttons (active-high)
//   o_level      : debounced levels
//   o_press      : 1-cycle pulses on accepted presses
//   o_release    : 1-cycle pulses on accepted releases
//   o_repeat     : 1-cycle auto-repeat pulses while held
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 2,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DLY   = 50_000_000,
  parameter int unsigned REPEAT_PER   = 20_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_repeat
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_btn     (i_btn[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_repeat  (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with N_BTN=2, DEBOUNCE_CYC=4,
// REPEAT_DLY=10, REPEAT_PER=3. Expected outputs per channel are packed as
// {level, press, release, repeat}. Tick t = t-th rising edge after the input
// change; a raw press reaches o_press at tick 7.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] level, press, rel, rep;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(
    .N_BTN        (2),
    .DEBOUNCE_CYC (4),
    .REPEAT_DLY   (10),
    .REPEAT_PER   (3)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn     (btn),
    .o_level   (level),
    .o_press   (press),
    .o_release (rel),
    .o_repeat  (rep)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] outs(input int ch);
    return {level[ch], press[ch], rel[ch], rep[ch]};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive btn0 high for n_high edges then low; count ch0 pulses.
  task automatic burst(input int n_high, input int n_total,
                       output int np, output int nr, output int nrep);
    np = 0; nr = 0; nrep = 0;
    btn[0] = 1'b1;
    for (int t = 1; t <= n_total; t++) begin
      tick(1);
      if (press[0]) np++;
      if (rel[0])   nr++;
      if (rep[0])   nrep++;
      if (t == n_high) btn[0] = 1'b0;
    end
  endtask

  // Per-tick check of ch0 (and ch1 quiet) while btn0 is held; btn0 dropped
  // after tick off_t, and optionally low from after b0 until after b1.
  task automatic scan(input string nm, input int n, input int press_t, input int rel_t,
                      input logic [63:0] rep_mask, input int off_t,
                      input int b0, input int b1);
    logic [3:0] e;
    for (int t = 1; t <= n; t++) begin
      tick(1);
      e = {(t >= press_t) && (t < rel_t), t == press_t, t == rel_t, rep_mask[t]};
      chk($sformatf("%s_ch0_t%0d", nm, t), outs(0), e);
      chk($sformatf("%s_ch1_t%0d", nm, t), outs(1), 4'b0000);
      if (t == off_t) btn[0] = 1'b0;
      if (t == b0)    btn[0] = 1'b0;
      if (t == b1)    btn[0] = 1'b1;
    end
  endtask

  initial begin
    int np, nr, nrep;
    logic [63:0] m;

    // Reset while both buttons are held
    rst = 1'b1;
    btn = 2'b11;
    tick(2);
    chk("rst_ch0", outs(0), 4'b0000);
    chk("rst_ch1", outs(1), 4'b0000);
    rst = 1'b0;
    tick(6);
    chk("post_rst_wait_ch0", outs(0), 4'b0000);
    chk("post_rst_wait_ch1", outs(1), 4'b0000);
    tick(1);
    chk("post_rst_press_ch0", outs(0), 4'b1100);
    chk("post_rst_press_ch1", outs(1), 4'b1100);
    tick(1);
    chk("post_rst_level_ch0", outs(0), 4'b1000);
    btn = 2'b00;
    tick(6);
    chk("rel_wait_ch0", outs(0), 4'b1000);
    chk("rel_wait_ch1", outs(1), 4'b1000);
    tick(1);
    chk("rel_ch0", outs(0), 4'b0010);
    chk("rel_ch1", outs(1), 4'b0010);
    tick(1);
    chk("rel_done_ch0", outs(0), 4'b0000);
    tick(3);

    // Debounce boundary: 4 samples rejected, 5 accepted
    burst(4, 15, np, nr, nrep);
    chk_int("glitch4_press", np, 0);
    chk_int("glitch4_release", nr, 0);
    chk("glitch4_level", outs(0), 4'b0000);
    burst(5, 25, np, nr, nrep);
    chk_int("pulse5_press", np, 1);
    chk_int("pulse5_release", nr, 1);
    chk_int("pulse5_repeat", nrep, 0);
    chk("pulse5_level", outs(0), 4'b0000);
    tick(3);

    // Long hold: press 7, repeats 17,20,...,41, release 47, nothing after
    m = '0;
    for (int k = 0; k < 9; k++) m[17 + 3 * k] = 1'b1;
    btn[0] = 1'b1;
    scan("hold", 60, 7, 47, m, 40, -1, -1);
    tick(3);

    // Hold with a 3-cycle bounce after tick 21: repeat 26 slips to 29
    m = '0;
    m[17] = 1'b1; m[20] = 1'b1; m[23] = 1'b1;
    m[29] = 1'b1; m[32] = 1'b1; m[35] = 1'b1;
    btn[0] = 1'b1;
    scan("bounce", 50, 7, 42, m, 35, 21, 24);
    tick(3);

    // Simultaneous press; ch1 released while ch0 keeps repeating
    btn = 2'b11;
    tick(7);
    chk("dual_press_ch0", outs(0), 4'b1100);
    chk("dual_press_ch1", outs(1), 4'b1100);
    tick(1);
    btn[1] = 1'b0;
    tick(7);
    chk("dual_rel1_ch0", outs(0), 4'b1000);
    chk("dual_rel1_ch1", outs(1), 4'b0010);
    tick(2);
    chk("dual_rep_ch0", outs(0), 4'b1001);
    chk("dual_rep_ch1", outs(1), 4'b0000);
    btn[0] = 1'b0;
    tick(3);
    chk("dual_norep_ch0", outs(0), 4'b1000);
    tick(4);
    chk("dual_rel0_ch0", outs(0), 4'b0010);
    tick(3);

    // Reset mid-DB_PRESS: no pulse, then a fresh press from IDLE
    btn[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("rst_dbp_ch0", outs(0), 4'b0000);
    tick(1);
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick(1);
      chk($sformatf("rst_dbp_wait_t%0d", t), outs(0), 4'b0000);
    end
    tick(1);
    chk("rst_dbp_press", outs(0), 4'b1100);
    tick(2);
    chk("held_before_rst", outs(0), 4'b1000);

    // Reset mid-HELD: level drops next cycle, no release pulse afterwards
    rst = 1'b1;
    btn[0] = 1'b0;
    tick(1);
    chk("rst_held_ch0", outs(0), 4'b0000);
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      chk($sformatf("rst_held_quiet_t%0d", t), outs(0), 4'b0000);
    end
    btn[0] = 1'b1;
    tick(6);
    chk("restart_wait", outs(0), 4'b0000);
    tick(1);
    chk("restart_press", outs(0), 4'b1100);
    btn[0] = 1'b0;
    tick(7);
    chk("restart_rel", outs(0), 4'b0010);
    tick(1);
    chk("restart_idle", outs(0), 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
